// File: rtl/bus_pkg.sv
// Shared definitions for the tri-state bus arbiter and its integrating level:
// the arbiter state encoding, the default bus data width used by the buffer
// instances, and the hold-counter width used when BUS_ARBITER_TIMEOUT_EN is defined.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_e;

  localparam int BUS_W  = 16;
  localparam int HOLD_W = 8;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: finds the first set request bit searching
// upward from (last_owner + 1) mod N, wrapping around.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last_owner,
  output logic                 found,
  output logic [$clog2(N)-1:0] index
);

  localparam int IDW = $clog2(N);

  logic [IDW-1:0] cand_s;

  // Walk the offsets from farthest to nearest so the nearest hit wins last.
  always_comb begin
    found  = 1'b0;
    index  = '0;
    cand_s = '0;
    for (int i = N; i >= 1; i--) begin
      cand_s = IDW'((int'(last_owner) + i) % N);
      if (req[cand_s]) begin
        found = 1'b1;
        index = cand_s;
      end else begin
        found = found;
        index = index;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for N requesters sharing one tri-state bus.
// Each grant is followed by one all-zero turnaround cycle on cs before the next owner.
// Optional feature: define BUS_ARBITER_TIMEOUT_EN to force release of an owner
// that keeps the bus for MAX_HOLD cycles, pulsing timeout on entry to TURN.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         done,
  output logic [N-1:0]         cs,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 busy,
  output logic                 timeout
);

  localparam int IDW = $clog2(N);

  state_e         state_q, state_d;
  logic [N-1:0]   cs_q, cs_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic [IDW-1:0] last_owner_q, last_owner_d;
  logic           busy_q, busy_d;

  logic           pick_found_s;
  logic [IDW-1:0] pick_idx_s;
  logic           natural_s;
  logic           force_s;
  logic           release_s;

  rr_pick #(.N(N)) u_rr_pick (
    .req        (req),
    .last_owner (last_owner_q),
    .found      (pick_found_s),
    .index      (pick_idx_s)
  );

  // Only the owner's own done/req can end its tenure; other bits are ignored.
  assign natural_s = done[gnt_id_q] | ~req[gnt_id_q];
  assign release_s = natural_s | force_s;

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              timeout_q, timeout_d;

  assign force_s = (state_q == GRANT) && (hold_cnt_q == HOLD_LAST);

  // Count cycles spent in GRANT; a forced release without a natural one pulses timeout.
  always_comb begin
    hold_cnt_d = '0;
    timeout_d  = 1'b0;
    if (state_q == GRANT) begin
      if (release_s) begin
        hold_cnt_d = '0;
        timeout_d  = force_s & ~natural_s;
      end else begin
        hold_cnt_d = hold_cnt_q + 8'd1;
        timeout_d  = 1'b0;
      end
    end else begin
      hold_cnt_d = '0;
      timeout_d  = 1'b0;
    end
  end

  // Hold counter and timeout pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign force_s = 1'b0;
  assign timeout = 1'b0;
`endif

  // Next-state and next-output logic; IDLE and TURN both arbitrate.
  always_comb begin
    state_d      = state_q;
    cs_d         = cs_q;
    gnt_id_d     = gnt_id_q;
    busy_d       = busy_q;
    last_owner_d = last_owner_q;
    case (state_q)
      IDLE, TURN: begin
        if (pick_found_s) begin
          state_d      = GRANT;
          cs_d         = {{(N-1){1'b0}}, 1'b1} << pick_idx_s;
          gnt_id_d     = pick_idx_s;
          busy_d       = 1'b1;
          last_owner_d = pick_idx_s;
        end else begin
          state_d  = IDLE;
          cs_d     = '0;
          gnt_id_d = '0;
          busy_d   = 1'b0;
        end
      end
      GRANT: begin
        if (release_s) begin
          state_d  = TURN;
          cs_d     = '0;
          gnt_id_d = '0;
          busy_d   = 1'b0;
        end else begin
          state_d  = GRANT;
          cs_d     = cs_q;
          gnt_id_d = gnt_id_q;
          busy_d   = 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        cs_d     = '0;
        gnt_id_d = '0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset clears cs asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cs_q         <= '0;
      gnt_id_q     <= '0;
      busy_q       <= 1'b0;
      last_owner_q <= IDW'(N - 1);
    end else begin
      state_q      <= state_d;
      cs_q         <= cs_d;
      gnt_id_q     <= gnt_id_d;
      busy_q       <= busy_d;
      last_owner_q <= last_owner_d;
    end
  end

  assign cs     = cs_q;
  assign gnt_id = gnt_id_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter (N=4, MAX_HOLD=3). Directed scenarios plus
// a randomized run, all compared against an ownership-level reference model.
module tb_bus_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 3;
`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req   = '0;
  logic [N-1:0] done  = '0;
  logic [N-1:0] cs;
  logic [1:0]   gnt_id;
  logic         busy;
  logic         timeout;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who owns the bus (-1 = nobody), who owned it last,
  // how many cycles the owner has had it, and whether a forced release just happened.
  int m_owner;
  int m_last;
  int m_held;
  bit m_to;

  bus_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .cs      (cs),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  function automatic int rr_next(int last, logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_cs();
    logic [N-1:0] one;
    one = 4'b0001;
    return (m_owner >= 0) ? (one << m_owner) : 4'b0000;
  endfunction

  function automatic logic [1:0] exp_id();
    return (m_owner >= 0) ? 2'(m_owner) : 2'd0;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_held  = 0;
    m_to    = 1'b0;
  endtask

  // One clock edge of the reference model, using the inputs present at the edge.
  task automatic model_edge();
    bit nat;
    bit frc;
    int w;
    m_to = 1'b0;
    if (m_owner >= 0) begin
      nat = done[m_owner] || !req[m_owner];
      frc = TEN && (m_held >= MAX_HOLD);
      if (nat || frc) begin
        m_to    = frc && !nat;
        m_owner = -1;
      end else begin
        m_held++;
      end
    end else begin
      w = rr_next(m_last, req);
      if (w >= 0) begin
        m_owner = w;
        m_last  = w;
        m_held  = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    done  = '0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    model_reset();
    #12;
    n_tests++; if (cs !== 4'b0000) begin n_fail++; $display("FAIL reset_cs got=%b exp=0000", cs); end
    n_tests++; if (gnt_id !== 2'd0) begin n_fail++; $display("FAIL reset_gnt_id got=%0d exp=0", gnt_id); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_tests++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
    req = 4'b1111;
    @(posedge clk);
    #1;
    n_tests++; if (cs !== 4'b0000) begin n_fail++; $display("FAIL reset_hold_cs got=%b exp=0000", cs); end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0001;
    tick();
    n_tests++; if (cs !== 4'b0001 || gnt_id !== 2'd0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL single_grant got cs=%b id=%0d busy=%b exp cs=0001 id=0 busy=1", cs, gnt_id, busy);
    end
    tick();
    n_tests++; if (cs !== exp_cs() || cs !== 4'b0001) begin n_fail++; $display("FAIL single_hold got=%b exp=0001", cs); end
    done = 4'b0001;
    req  = 4'b0000;
    tick();
    done = '0;
    n_tests++; if (cs !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL single_release got cs=%b busy=%b exp 0000/0", cs, busy); end
    tick();
    n_tests++; if (cs !== 4'b0000 || cs !== exp_cs()) begin n_fail++; $display("FAIL single_idle got=%b exp=0000", cs); end
  endtask

  task automatic test_back_to_back();
    int order[$];
    int exp_order[5];
    int held;
    int gap;
    exp_order = '{0, 1, 2, 3, 0};
    do_reset();
    req  = 4'b1111;
    held = 0;
    gap  = 0;
    for (int c = 0; c < 40 && order.size() < 5; c++) begin
      tick();
      done = '0;
      n_tests++; if (cs !== exp_cs() || gnt_id !== exp_id()) begin
        n_fail++; $display("FAIL b2b_model cyc=%0d got cs=%b id=%0d exp cs=%b id=%0d", c, cs, gnt_id, exp_cs(), exp_id());
      end
      if (cs !== 4'b0000) begin
        if (held == 0) begin
          order.push_back(int'(gnt_id));
          if (order.size() > 1) begin
            n_tests++; if (gap != 1) begin n_fail++; $display("FAIL b2b_gap got=%0d exp=1", gap); end
          end
        end
        held++;
        gap = 0;
        if (held == 2) done = cs;
      end else begin
        gap++;
        held = 0;
      end
    end
    n_tests++; if (order.size() != 5) begin n_fail++; $display("FAIL b2b_count got=%0d exp=5", order.size()); end
    for (int i = 0; i < order.size() && i < 5; i++) begin
      n_tests++; if (order[i] != exp_order[i]) begin n_fail++; $display("FAIL b2b_order idx=%0d got=%0d exp=%0d", i, order[i], exp_order[i]); end
    end
    req  = '0;
    done = '0;
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    req = 4'b0100;
    tick();
    n_tests++; if (cs !== 4'b0100) begin n_fail++; $display("FAIL wrap_first got=%b exp=0100", cs); end
    req = 4'b1001;
    tick();
    n_tests++; if (cs !== 4'b0000) begin n_fail++; $display("FAIL wrap_turn got=%b exp=0000", cs); end
    tick();
    n_tests++; if (cs !== 4'b1000 || gnt_id !== 2'd3 || cs !== exp_cs()) begin
      n_fail++; $display("FAIL wrap_owner3 got cs=%b id=%0d exp cs=1000 id=3", cs, gnt_id);
    end
    done = 4'b1000;
    req  = 4'b0001;
    tick();
    done = '0;
    tick();
    n_tests++; if (cs !== 4'b0001 || gnt_id !== 2'd0) begin
      n_fail++; $display("FAIL wrap_owner0 got cs=%b id=%0d exp cs=0001 id=0", cs, gnt_id);
    end
    req  = '0;
    done = 4'b0001;
    tick();
    done = '0;
  endtask

  task automatic test_noise();
    do_reset();
    req = 4'b0010;
    tick();
    n_tests++; if (cs !== 4'b0010) begin n_fail++; $display("FAIL noise_grant got=%b exp=0010", cs); end
    done = 4'b0100;
    req  = 4'b1111;
    tick();
    done = '0;
    n_tests++; if (cs !== 4'b0010 || cs !== exp_cs()) begin n_fail++; $display("FAIL noise_ignored got=%b exp=0010", cs); end
    // Owner drops req and pulses done together: one release only.
    req  = 4'b1101;
    done = 4'b0010;
    tick();
    done = '0;
    n_tests++; if (cs !== 4'b0000) begin n_fail++; $display("FAIL noise_release got=%b exp=0000", cs); end
    tick();
    n_tests++; if (cs !== 4'b0100 || cs !== exp_cs()) begin n_fail++; $display("FAIL noise_next got=%b exp=0100", cs); end
    req  = '0;
    done = 4'b0100;
    tick();
    done = '0;
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 4'b0100;
    tick();
    n_tests++; if (cs !== 4'b0100) begin n_fail++; $display("FAIL rstmid_grant got=%b exp=0100", cs); end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_tests++; if (cs !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_async got cs=%b busy=%b exp 0000/0", cs, busy); end
    rst_n = 1'b1;
    req   = 4'b0001;
    tick();
    n_tests++; if (cs !== 4'b0001 || cs !== exp_cs()) begin n_fail++; $display("FAIL rstmid_regrant got=%b exp=0001", cs); end
    req = '0;
    tick();
  endtask

`ifdef BUS_ARBITER_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    req = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++; if (cs !== 4'b0001 || timeout !== 1'b0) begin
        n_fail++; $display("FAIL to_hold cyc=%0d got cs=%b to=%b exp cs=0001 to=0", i, cs, timeout);
      end
    end
    tick();
    n_tests++; if (cs !== 4'b0000 || timeout !== 1'b1 || timeout !== m_to) begin
      n_fail++; $display("FAIL to_force got cs=%b to=%b exp cs=0000 to=1", cs, timeout);
    end
    tick();
    n_tests++; if (cs !== 4'b0010 || timeout !== 1'b0) begin
      n_fail++; $display("FAIL to_next got cs=%b to=%b exp cs=0010 to=0", cs, timeout);
    end
    req = '0;
    tick();
  endtask
`else
  task automatic test_hold_forever();
    do_reset();
    req = 4'b0011;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_tests++; if (cs !== 4'b0001 || timeout !== 1'b0) begin
        n_fail++; $display("FAIL hold_forever cyc=%0d got cs=%b to=%b exp cs=0001 to=0", i, cs, timeout);
      end
    end
    req = '0;
    tick();
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(3, 0) == 0) req[b] = ~req[b];
      end
      if ($urandom_range(2, 0) == 0) done = cs;
      else if ($urandom_range(4, 0) == 0) done = 4'b0001 << $urandom_range(3, 0);
      else done = '0;
      tick();
      done = '0;
      n_tests++; if (cs !== exp_cs() || gnt_id !== exp_id() || busy !== (m_owner >= 0) || timeout !== m_to) begin
        n_fail++; $display("FAIL rand_model cyc=%0d got cs=%b id=%0d busy=%b to=%b exp cs=%b id=%0d busy=%b to=%b",
                           c, cs, gnt_id, busy, timeout, exp_cs(), exp_id(), (m_owner >= 0), m_to);
      end
      n_tests++; if ($countones(cs) > 1) begin n_fail++; $display("FAIL rand_onehot cyc=%0d got=%b exp=at most one bit", c, cs); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_noise();
    test_reset_mid_grant();
`ifdef BUS_ARBITER_TIMEOUT_EN
    test_timeout();
`else
    test_hold_forever();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
